rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in cycles when timeout is compiled in; legal range 2..256.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req, input, 8, one request line per requester; bit i belongs to requester i.
REQ-005 SHALL have port gnt, output, 8, one-hot grant, or all-zero when idle.
REQ-006 SHALL have port gnt_idx, output, 3, binary index of the set gnt bit, using the 8-to-3 encoding (bit i -> i); 3'b000 when idle.
REQ-007 SHALL have port gnt_valid, output, 1, high exactly when gnt is non-zero.
REQ-008 SHALL have port timeout, output, 1, one-cycle pulse when a grant is forcibly revoked.

Function
REQ-009 SHALL implement two states: IDLE (no grant) and GRANT (one owner holds gnt).
REQ-010 SHALL keep a 3-bit priority pointer ptr; the winner is the first set req bit found scanning ptr, ptr+1, ... wrapping 7->0.
REQ-011 SHALL go IDLE->GRANT at the edge after any req bit is sampled high, so gnt appears 1 cycle after req.
REQ-012 SHALL register all outputs; no combinational path from req to gnt, gnt_idx or gnt_valid.
REQ-013 SHALL hold gnt on the owner while req[owner] stays high, except as REQ-020 allows; requests from other requesters never pre-empt the owner.
REQ-014 SHALL, when req[owner] is sampled low, re-arbitrate in the same cycle among the other sampled req bits: on the next edge either grant the new winner (no bubble cycle) or return to IDLE if none are set.
REQ-015 SHALL set ptr to owner+1 mod 8 on every new grant; a grant to 7 sets ptr to 0.
REQ-016 SHALL, if the owner drops req and re-raises it in the same cycle as others request, treat it as lowest priority for that arbitration by virtue of ptr.
REQ-017 SHALL keep gnt one-hot, with gnt_idx consistent with gnt and gnt_valid = |gnt, in every cycle.
REQ-018 SHALL ignore req bits for requesters not granted; there is no request latching, and a request withdrawn before it is granted is lost.

Reset
REQ-019 SHALL, on rst_n low and at any time, including mid-grant, immediately force state IDLE, ptr=0, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, timeout=0 and hold count=0; arbitration resumes on the first edge with rst_n high.

Configuration
REQ-020 SHALL, with macro RR_ARB_TIMEOUT_EN defined, count the cycles of the owner's tenure.
- When the count reaches MAX_HOLD and any other req bit is set, the next edge grants the next winner per ptr, pulses timeout for 1 cycle and clears the count.
- If no other req bit is set, the owner keeps the grant and the count saturates.
REQ-021 SHALL, without RR_ARB_TIMEOUT_EN, contain no hold counter; timeout is tied 0 and the grant is held indefinitely per REQ-013.

Verification
REQ-022 SHALL cover reset then req=8'h01 -> next cycle gnt=8'h01, gnt_idx=0, gnt_valid=1, ptr=1.
REQ-023 SHALL cover req=8'hFF held, with each owner dropping its bit for 1 cycle after grant -> grants 0,1,...,7,0 in order, no idle cycle between them.
REQ-024 SHALL cover owner 7 dropping while req=8'h81 -> gnt=8'h01, ptr wraps to 0 then 1.
REQ-025 SHALL cover owner 3, with req[5] rising mid-grant -> gnt stays 8'h08 until req[3] drops, then next edge gnt=8'h20, gnt_idx=5.
REQ-026 SHALL cover RR_ARB_TIMEOUT_EN with MAX_HOLD=4 and req=8'h03 held constant -> owner 0 for 4 cycles, then gnt=8'h02 with timeout=1 for 1 cycle; without the macro -> owner 0 forever, timeout=0.
REQ-027 SHALL cover rst_n asserted mid-grant to requester 4 -> outputs zero asynchronously; after release with req=8'h10, grant to 4 after 1 cycle.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with registered one-hot grant
//
// Purpose:
//   Grants one of eight requesters at a time. The winner is the first set
//   request found scanning from the priority pointer upward, wrapping 7->0.
//   The owner keeps the grant while its request stays high; when it drops,
//   the next winner is granted on the following edge with no idle bubble.
//
// Optional feature (macro RR_ARB_TIMEOUT_EN):
//   When defined, the owner's tenure is counted; after MAX_HOLD cycles the
//   grant is revoked in favour of another requester (if any) and timeout
//   pulses for one cycle. When undefined there is no counter and timeout is 0.
//
// Parameters:
//   MAX_HOLD  - maximum grant tenure in cycles with timeout enabled (2..256)
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - request lines, bit i from requester i
//   gnt       - registered one-hot grant, zero when idle
//   gnt_idx   - binary index of the granted requester, 0 when idle
//   gnt_valid - high exactly when gnt is non-zero
//   timeout   - one-cycle pulse when a grant is forcibly revoked

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [0:0] nxt_state;
    logic [2:0] ptr;
    logic [2:0] nxt_ptr;
    logic [7:0] nxt_gnt;
    logic [2:0] nxt_idx;
    logic       nxt_timeout;

    // Arbitration candidates exclude the current owner: it either dropped its
    // request (bit already low) or is being timed out, and in both cases it
    // must not win. When idle gnt is zero, so nothing is masked.
    logic [7:0] req_m;
    logic [2:0] cand;
    logic [2:0] win;
    logic       win_found;

    always_comb begin
        req_m     = req & ~gnt;
        cand      = ptr;
        win       = ptr;
        win_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req_m[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    // count holds the number of cycles the current owner has had gnt,
    // including the present one; a fresh grant therefore loads 1.
    logic [CW-1:0] count;
    logic [CW-1:0] nxt_count;
    logic          hold_expired;

    assign hold_expired = (count >= CW'(MAX_HOLD));
`endif

    always_comb begin
        nxt_state   = state;
        nxt_ptr     = ptr;
        nxt_gnt     = gnt;
        nxt_idx     = gnt_idx;
        nxt_timeout = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        nxt_count   = count;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    nxt_state = GRANT;
                    nxt_gnt   = 8'h01 << win;
                    nxt_idx   = win;
                    nxt_ptr   = win + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
                    nxt_count = CW'(1);
`endif
                end
            end
            default: begin
                if (!req[gnt_idx]) begin
                    if (win_found) begin
                        nxt_gnt   = 8'h01 << win;
                        nxt_idx   = win;
                        nxt_ptr   = win + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
                        nxt_count = CW'(1);
`endif
                    end else begin
                        nxt_state = IDLE;
                        nxt_gnt   = 8'h00;
                        nxt_idx   = 3'd0;
`ifdef RR_ARB_TIMEOUT_EN
                        nxt_count = '0;
`endif
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_expired && win_found) begin
                    nxt_gnt     = 8'h01 << win;
                    nxt_idx     = win;
                    nxt_ptr     = win + 3'd1;
                    nxt_timeout = 1'b1;
                    nxt_count   = CW'(1);
                end else if (!hold_expired) begin
                    nxt_count = count + CW'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            gnt       <= nxt_gnt;
            gnt_idx   <= nxt_idx;
            gnt_valid <= |nxt_gnt;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            count   <= nxt_count;
            timeout <= nxt_timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_assert;
    int n_fail;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
        chk({tag, ".gnt"}, {24'h0, gnt}, {24'h0, eg});
        chk({tag, ".gnt_idx"}, {29'h0, gnt_idx}, {29'h0, ei});
        chk({tag, ".gnt_valid"}, {31'h0, gnt_valid}, {31'h0, ev});
        chk({tag, ".timeout"}, {31'h0, timeout}, {31'h0, et});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; reset pulse completes before the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 8'h00;

        step();
        step();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset.ptr", {29'h0, dut.ptr}, 32'd0);
        rst_n = 1'b1;

        // single request, 1-cycle latency
        req = 8'h01;
        step();
        chk_out("req01", 8'h01, 3'd0, 1'b1, 1'b0);
        chk("req01.ptr", {29'h0, dut.ptr}, 32'd1);
        req = 8'h00;
        step();
        chk_out("idle_after_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // full rotation with every owner dropping for one cycle
        pulse_reset();
        req = 8'hFF;
        step();
        chk_out("rot_first", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] drop;
            logic [2:0] nxt;
            drop = 8'h01 << i;
            nxt  = 3'(i + 1);
            req  = 8'hFF & ~drop;
            step();
            chk_out($sformatf("rot_%0d", i), 8'h01 << nxt, nxt, 1'b1, 1'b0);
        end

        // owner 0, ptr 1: hand to 7, then 7 drops while 0 requests -> wrap
        req = 8'h80;
        step();
        chk_out("to7", 8'h80, 3'd7, 1'b1, 1'b0);
        chk("to7.ptr", {29'h0, dut.ptr}, 32'd0);
        req = 8'h01;
        step();
        chk_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        chk("wrap0.ptr", {29'h0, dut.ptr}, 32'd1);

        // owner 3 is not pre-empted by req[5]
        req = 8'h08;
        step();
        chk_out("own3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h28;
        step();
        chk_out("own3_hold_a", 8'h08, 3'd3, 1'b1, 1'b0);
        step();
        chk_out("own3_hold_b", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h20;
        step();
        chk_out("own5", 8'h20, 3'd5, 1'b1, 1'b0);

        // ptr=6 after grant to 5: 7 beats 2
        req = 8'h84;
        step();
        chk_out("prio7", 8'h80, 3'd7, 1'b1, 1'b0);

        // constant req=8'h03 from reset
        pulse_reset();
        req = 8'h03;
        step();
        chk_out("hold_c1", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk_out($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step();
`ifdef RR_ARB_TIMEOUT_EN
        chk_out("hold_c5", 8'h02, 3'd1, 1'b1, 1'b1);
        step();
        chk_out("hold_c6", 8'h02, 3'd1, 1'b1, 1'b0);
`else
        chk_out("hold_c5", 8'h01, 3'd0, 1'b1, 1'b0);
        step();
        chk_out("hold_c6", 8'h01, 3'd0, 1'b1, 1'b0);
`endif

        // asynchronous reset mid-grant to requester 4
        pulse_reset();
        req = 8'h10;
        step();
        chk_out("own4", 8'h10, 3'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("rst_held.ptr", {29'h0, dut.ptr}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk_out("after_rst", 8'h10, 3'd4, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
